// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file geometry constants and typedefs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int LANES     = 8;
    localparam int DATA_W    = 64;
    localparam int NUM_WARPS = 16;
    localparam int NUM_REGS  = 32;

    localparam int WARP_W    = $clog2(NUM_WARPS);
    localparam int REG_W     = $clog2(NUM_REGS);

    typedef logic [WARP_W-1:0]                 warp_t;
    typedef logic [REG_W-1:0]                  reg_addr_t;
    typedef logic [LANES-1:0]                  lane_mask_t;
    typedef logic [LANES-1:0][DATA_W-1:0]      lane_data_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Write-back request bundle shared by all requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LANES   = regfile_pkg::LANES,
    parameter int DATA_W  = regfile_pkg::DATA_W
);

    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0]                          req_ready;
    warp_t     [NUM_REQ-1:0]                     req_warp;
    reg_addr_t [NUM_REQ-1:0]                     req_addr;
    logic [NUM_REQ-1:0][LANES-1:0]               req_mask;
    logic [NUM_REQ-1:0][LANES-1:0][DATA_W-1:0]   req_data;

    modport master (
        output req_valid,
        output req_warp,
        output req_addr,
        output req_mask,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_warp,
        input  req_addr,
        input  req_mask,
        input  req_data,
        output req_ready
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Generic round-robin picker; search starts at ptr and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [c_ptr_w-1:0] ptr,
    output logic [NUM_REQ-1:0] grant
);

    int                 w_sum;
    logic [c_ptr_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = c_ptr_w'(w_sum);
            if (!w_found && eligible[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter feeding a register_block port.
//               Optional REGFILE_WB_PERF_CNT_EN adds grant/block counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LANES   = regfile_pkg::LANES,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    regfile_wb_arbiter_if.slave           req_if,
    input  logic                          rd_busy,
    input  warp_t                         rd_warp,
    input  logic                          wb_hold,
    output logic [LANES-1:0]              write_en,
    output reg_addr_t                     waddr,
    output logic [LANES-1:0][DATA_W-1:0]  wdata,
    output warp_t                         warp_selector
`ifdef REGFILE_WB_PERF_CNT_EN
    ,
    output logic [31:0]                   grant_cnt,
    output logic [31:0]                   block_cnt
`endif
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              w_eligible;
    logic [NUM_REQ-1:0]              w_grant;
    logic [c_ptr_w-1:0]              w_gnt_idx;
    logic                            w_xfer;
    logic [c_ptr_w-1:0]              w_ptr_next;

    logic [c_ptr_w-1:0]              r_rr_ptr;
    logic [LANES-1:0]                r_write_en;
    reg_addr_t                       r_waddr;
    logic [LANES-1:0][DATA_W-1:0]    r_wdata;
    warp_t                           r_warp_sel;

    // A busy read client pins warp_selector, so only same-warp writes may go.
    // Reset also masks eligibility so req_ready stays low while rst is high.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign w_eligible[i] = req_if.req_valid[i] && !wb_hold && !rst &&
                               (!rd_busy || (req_if.req_warp[i] == rd_warp));
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .eligible (w_eligible),
        .ptr      (r_rr_ptr),
        .grant    (w_grant)
    );

    assign req_if.req_ready = w_grant;
    assign w_xfer           = |w_grant;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = c_ptr_w'(i);
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_write_en <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_warp_sel <= '0;
        end else begin
            r_write_en <= w_xfer ? req_if.req_mask[w_gnt_idx] : '0;
            if (w_xfer) begin
                r_rr_ptr <= w_ptr_next;
                r_waddr  <= req_if.req_addr[w_gnt_idx];
                r_wdata  <= req_if.req_data[w_gnt_idx];
            end
            if (rd_busy) begin
                r_warp_sel <= rd_warp;
            end else if (w_xfer) begin
                r_warp_sel <= req_if.req_warp[w_gnt_idx];
            end
        end
    end

    assign write_en      = r_write_en;
    assign waddr         = r_waddr;
    assign wdata         = r_wdata;
    assign warp_selector = r_warp_sel;

`ifdef REGFILE_WB_PERF_CNT_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_block_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= '0;
            r_block_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end else if (|req_if.req_valid) begin
                r_block_cnt <= r_block_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign block_cnt = r_block_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write-back requesters.
REQ-002 Parameter LANES, default 8: lanes per register_block write.
REQ-003 Parameter DATA_W, default 64: data width per lane.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester write-back valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_warp  in  NUM_REQ x 4  target warp per requester.
REQ-009 req_addr  in  NUM_REQ x 5  target register per requester.
REQ-010 req_mask  in  NUM_REQ x LANES  lane write mask per requester.
REQ-011 req_data  in  NUM_REQ x LANES x DATA_W  lane data per requester.
REQ-012 rd_busy  in  1  read client claims warp_selector for the next cycle.
REQ-013 rd_warp  in  4  warp the read client needs.
REQ-014 wb_hold  in  1  pipeline stall; no grants while high.
REQ-015 write_en  out  LANES  register_block write enable.
REQ-016 waddr  out  5  register_block write address.
REQ-017 wdata  out  LANES x DATA_W  register_block write data, lane 0 in LSBs.
REQ-018 warp_selector  out  4  register_block warp select.

Function
REQ-019 Eligible(i) = req_valid[i] && !wb_hold && (!rd_busy || req_warp[i]==rd_warp).
REQ-020 Grant is round-robin: search starts at rr_ptr, ascends, wraps NUM_REQ-1 -> 0; first eligible wins.
REQ-021 req_ready[i] is combinational, high only for the granted requester; transfer = valid && ready.
REQ-022 A requester with valid high and ready low holds warp/addr/mask/data stable until transfer.
REQ-023 On transfer from i, rr_ptr <= (i+1) mod NUM_REQ; with no transfer, rr_ptr holds.
REQ-024 Latency 1: on transfer in cycle T, cycle T+1 has write_en=req_mask[i], waddr, wdata, warp_selector=req_warp[i].
REQ-025 Cycle with no transfer: write_en=0 next cycle; waddr and wdata hold.
REQ-026 warp_selector next = rd_warp if rd_busy, else granted warp on transfer, else hold.
REQ-027 rd_busy and transfer in the same cycle never conflict: REQ-019 forces matching warps.
REQ-028 Zero req_mask is granted and consumed normally; write_en=0 results.
REQ-029 wb_hold high: all req_ready low, write_en=0 next cycle, warp_selector still follows REQ-026.

Reset
REQ-030 While rst high: write_en=0, waddr=0, wdata=0, warp_selector=0, rr_ptr=0, req_ready=0.
REQ-031 Reset asserted mid-transfer discards the in-flight write; the requester re-presents after reset.
REQ-032 First grant after reset release goes to the lowest-index eligible requester.

Configuration
REQ-033 Macro REGFILE_WB_PERF_CNT_EN adds outputs grant_cnt (32) and block_cnt (32).
REQ-034 With the macro: grant_cnt increments on each transfer; block_cnt increments each cycle with any req_valid high and no transfer; both wrap, reset to 0.
REQ-035 Without the macro: neither port nor counter logic exists; all other behaviour is identical.

Structure
REQ-036 Package regfile_pkg holds LANES, DATA_W, NUM_WARPS=16, NUM_REGS=32 and typedefs warp_t, reg_addr_t, lane_mask_t, lane_data_t.
REQ-037 Sub-module rr_arbiter: generic NUM_REQ round-robin picker (eligible vector, pointer in; one-hot grant out).

Verification
REQ-038 Requesters 0 and 2 valid every cycle, warp 3, addr 5 and 9 -> grants alternate 0,2,0,2; write_en=8'hFF one cycle after each grant.
REQ-039 rd_busy=1, rd_warp=7; req1 warp 7, req0 warp 2 -> req1 granted, req0 blocked; warp_selector=7 next cycle.
REQ-040 wb_hold=1 for 3 cycles with all 4 valid -> req_ready=0, write_en=0; first grant after release follows rr_ptr.
REQ-041 rst pulsed while req3 being granted -> outputs 0 asynchronously; after release req0 (if valid) wins before req3.
REQ-042 Macro defined: 10 transfers and 4 blocked cycles -> grant_cnt=10, block_cnt=4.
REQ-043 End-to-end with register_block: write random data to all 32 registers of all 16 warps through 4 requesters; read back matches every lane.
